// File: rtl/pc_sequencer.sv
// Program-counter sequencer: arbitrates redirects, stalls and halt for a
// single-issue pipeline, with a sticky watchdog on long STALL residency.
module pc_sequencer #(
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_branch_taken,
  input  logic [31:0] ip_branch_target,
  input  logic        ip_jal,
  input  logic [31:0] ip_jal_target,
  input  logic        ip_load_use,
  input  logic        ip_muldiv_busy,
  input  logic        ip_icache_ready,
  input  logic        ip_done_execute,
  output logic        op_stall_ctrl,
  output logic        op_jump_branch_ctrl,
  output logic [31:0] op_target_addr,
  output logic        op_flush_if_id,
  output logic        op_flush_id_ex,
  output logic        op_bubble_id_ex,
  output logic        op_halted,
  output logic        op_stall_timeout,
  output logic [1:0]  op_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_PEND  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pend_addr_reg, pend_addr_next;
  logic [15:0] wdog_cnt_reg;
  logic [15:0] wdog_inc;
  logic        timeout_reg;

  logic        stall_src;
  logic        redir;
  logic [31:0] sel_target;

  logic        stall_c;
  logic        jump_c;
  logic [31:0] target_c;
  logic        flush_if_id_c;
  logic        flush_id_ex_c;
  logic        bubble_c;
  logic        halted_c;

  assign stall_src  = ip_load_use | ip_muldiv_busy | ~ip_icache_ready;
  assign redir      = ip_branch_taken | ip_jal;
  // The older instruction (EX branch) wins over the younger ID jump.
  assign sel_target = ip_branch_taken ? ip_branch_target : ip_jal_target;
  assign wdog_inc   = wdog_cnt_reg + 16'd1;

  always_comb begin
    state_next     = state_reg;
    pend_addr_next = pend_addr_reg;
    stall_c        = 1'b0;
    jump_c         = 1'b0;
    target_c       = 32'h0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    bubble_c       = 1'b0;
    halted_c       = 1'b0;
    unique case (state_reg)
      ST_RUN, ST_STALL: begin
        if (ip_done_execute) begin
          state_next = ST_HALT;
          stall_c    = 1'b1;
        end else if (redir) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = ip_branch_taken;
          if (ip_icache_ready) begin
            jump_c     = 1'b1;
            target_c   = sel_target;
            state_next = ST_RUN;
          end else begin
            // Fetch port busy: park the target until the cache can take it.
            pend_addr_next = sel_target;
            stall_c        = 1'b1;
            state_next     = ST_PEND;
          end
        end else if (stall_src) begin
          stall_c    = 1'b1;
          bubble_c   = ip_load_use;
          state_next = ST_STALL;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_PEND: begin
        if (ip_done_execute) begin
          state_next     = ST_HALT;
          pend_addr_next = 32'h0;
          stall_c        = 1'b1;
        end else if (ip_icache_ready) begin
          jump_c     = 1'b1;
          target_c   = pend_addr_reg;
          state_next = ST_RUN;
        end else begin
          stall_c = 1'b1;
        end
      end
      ST_HALT: begin
        halted_c = 1'b1;
        stall_c  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state_reg     <= ST_RUN;
      pend_addr_reg <= 32'h0;
      wdog_cnt_reg  <= 16'h0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_addr_reg <= pend_addr_next;
      if (state_reg == ST_STALL) begin
        if (wdog_cnt_reg != 16'hFFFF) begin
          wdog_cnt_reg <= wdog_inc;
          if (wdog_inc == STALL_TIMEOUT) begin
            timeout_reg <= 1'b1;
          end
        end
      end else begin
        wdog_cnt_reg <= 16'h0;
      end
    end
  end

  // Reset forces every output low in the same cycle, whatever the state.
  assign op_stall_ctrl       = ~ip_rst & stall_c;
  assign op_jump_branch_ctrl = ~ip_rst & jump_c;
  assign op_target_addr      = ip_rst ? 32'h0 : target_c;
  assign op_flush_if_id      = ~ip_rst & flush_if_id_c;
  assign op_flush_id_ex      = ~ip_rst & flush_id_ex_c;
  assign op_bubble_id_ex     = ~ip_rst & bubble_c;
  assign op_halted           = ~ip_rst & halted_c;
  assign op_stall_timeout    = ~ip_rst & timeout_reg;
  assign op_state            = ip_rst ? 2'd0 : state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam int TO = 4;
  localparam logic [40:0] FULL     = {41{1'b1}};
  localparam logic [40:0] NO_STALL = FULL & ~(41'd1 << 32);

  logic        ip_clk = 1'b0;
  logic        ip_rst;
  logic        ip_branch_taken;
  logic [31:0] ip_branch_target;
  logic        ip_jal;
  logic [31:0] ip_jal_target;
  logic        ip_load_use;
  logic        ip_muldiv_busy;
  logic        ip_icache_ready;
  logic        ip_done_execute;
  logic        op_stall_ctrl;
  logic        op_jump_branch_ctrl;
  logic [31:0] op_target_addr;
  logic        op_flush_if_id;
  logic        op_flush_id_ex;
  logic        op_bubble_id_ex;
  logic        op_halted;
  logic        op_stall_timeout;
  logic [1:0]  op_state;

  int vectors     = 0;
  int miscompares = 0;

  pc_sequencer #(.STALL_TIMEOUT(16'd4)) dut (
    .ip_clk              (ip_clk),
    .ip_rst              (ip_rst),
    .ip_branch_taken     (ip_branch_taken),
    .ip_branch_target    (ip_branch_target),
    .ip_jal              (ip_jal),
    .ip_jal_target       (ip_jal_target),
    .ip_load_use         (ip_load_use),
    .ip_muldiv_busy      (ip_muldiv_busy),
    .ip_icache_ready     (ip_icache_ready),
    .ip_done_execute     (ip_done_execute),
    .op_stall_ctrl       (op_stall_ctrl),
    .op_jump_branch_ctrl (op_jump_branch_ctrl),
    .op_target_addr      (op_target_addr),
    .op_flush_if_id      (op_flush_if_id),
    .op_flush_id_ex      (op_flush_id_ex),
    .op_bubble_id_ex     (op_bubble_id_ex),
    .op_halted           (op_halted),
    .op_stall_timeout    (op_stall_timeout),
    .op_state            (op_state)
  );

  always #5 ip_clk = ~ip_clk;

  logic [40:0] obs;
  assign obs = {op_state, op_stall_timeout, op_halted, op_bubble_id_ex, op_flush_id_ex,
                op_flush_if_id, op_jump_branch_ctrl, op_stall_ctrl, op_target_addr};

  function automatic logic [40:0] pack(input logic [1:0] st, input bit to, input bit hl,
                                       input bit bub, input bit fex, input bit fif,
                                       input bit jmp, input bit stl, input logic [31:0] tgt);
    return {st, to, hl, bub, fex, fif, jmp, stl, tgt};
  endfunction

  task automatic idle();
    ip_rst = 1'b0; ip_branch_taken = 1'b0; ip_branch_target = 32'h0;
    ip_jal = 1'b0; ip_jal_target = 32'h0; ip_load_use = 1'b0;
    ip_muldiv_busy = 1'b0; ip_icache_ready = 1'b1; ip_done_execute = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ip_clk); idle(); ip_rst = 1'b1;
    @(negedge ip_clk); ip_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [40:0] e;
    @(negedge ip_clk); idle(); ip_rst = 1'b1;
    ip_branch_taken = 1'b1; ip_branch_target = $urandom; ip_load_use = 1'b1; #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL reset_hold: got %h expected %h", obs, 41'd0); end
    @(negedge ip_clk); idle(); ip_rst = 1'b1; ip_done_execute = 1'b1; #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL reset_hold2: got %h expected %h", obs, 41'd0); end
    @(negedge ip_clk); idle(); #1;
    e = pack(2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_release: got %h expected %h", obs, e); end
    $display("test_reset done");
  endtask

  task automatic test_branch_priority();
    logic [40:0] e;
    do_reset();
    @(negedge ip_clk); idle();
    ip_branch_taken = 1'b1; ip_branch_target = 32'h100; ip_jal = 1'b1; ip_jal_target = 32'h200; #1;
    e = pack(2'd0, 0, 0, 0, 1, 1, 1, 0, 32'h100);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL branch_over_jal: got %h expected %h", obs, e); end
    @(negedge ip_clk); idle(); #1;
    e = pack(2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL branch_after: got %h expected %h", obs, e); end
    $display("test_branch_priority done");
  endtask

  task automatic test_pend();
    logic [40:0] e;
    do_reset();
    @(negedge ip_clk); idle(); ip_jal = 1'b1; ip_jal_target = 32'h40; ip_icache_ready = 1'b0; #1;
    e = pack(2'd0, 0, 0, 0, 0, 1, 0, 1, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pend_request: got %h expected %h", obs, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge ip_clk); idle(); ip_icache_ready = 1'b0;
      if (i == 1) begin
        ip_branch_taken = 1'b1; ip_branch_target = 32'h80; ip_load_use = 1'b1; ip_muldiv_busy = 1'b1;
      end
      #1;
      e = pack(2'd2, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL pend_wait%0d: got %h expected %h", i, obs, e); end
    end
    @(negedge ip_clk); idle(); ip_branch_taken = 1'b1; ip_branch_target = 32'h80; #1;
    e = pack(2'd2, 0, 0, 0, 0, 0, 1, 0, 32'h40);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pend_issue: got %h expected %h", obs, e); end
    @(negedge ip_clk); idle(); #1;
    e = pack(2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pend_back_run: got %h expected %h", obs, e); end
    $display("test_pend done");
  endtask

  task automatic test_load_use();
    logic [40:0] e;
    do_reset();
    @(negedge ip_clk); idle(); ip_load_use = 1'b1; #1;
    e = pack(2'd0, 0, 0, 1, 0, 0, 0, 1, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL load_use_bubble: got %h expected %h", obs, e); end
    @(negedge ip_clk); idle(); #1;
    e = pack(2'd1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL load_use_stall: got %h expected %h", obs, e); end
    @(negedge ip_clk); idle(); #1;
    e = pack(2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL load_use_run: got %h expected %h", obs, e); end
    $display("test_load_use done");
  endtask

  task automatic test_watchdog();
    logic [40:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge ip_clk); idle(); ip_muldiv_busy = 1'b1; #1;
      // Cycle i has i-1 completed STALL cycles behind it (cycle 0 is still RUN).
      e = pack((i == 0) ? 2'd0 : 2'd1, (i - 1) >= TO, 0, 0, 0, 0, 0, 1, 32'h0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL watchdog_busy%0d: got %h expected %h", i, obs, e); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge ip_clk); idle(); #1;
      e = pack((i == 0) ? 2'd1 : 2'd0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL watchdog_sticky%0d: got %h expected %h", i, obs, e); end
    end
    $display("test_watchdog done");
  endtask

  task automatic test_halt();
    logic [40:0] e;
    do_reset();
    @(negedge ip_clk); idle(); ip_done_execute = 1'b1;
    ip_branch_taken = 1'b1; ip_branch_target = 32'h1234; #1;
    e = pack(2'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if ((obs & NO_STALL) !== e) begin miscompares++; $display("FAIL halt_no_redirect: got %h expected %h", obs & NO_STALL, e); end
    for (int i = 0; i < 2; i++) begin
      @(negedge ip_clk); idle(); ip_branch_taken = 1'b1; ip_jal = 1'b1; ip_load_use = (i == 1); #1;
      e = pack(2'd3, 0, 1, 0, 0, 0, 0, 1, 32'h0);
      vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL halt_hold%0d: got %h expected %h", i, obs, e); end
    end
    @(negedge ip_clk); idle(); ip_rst = 1'b1; #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL halt_reset_force: got %h expected %h", obs, 41'd0); end
    @(negedge ip_clk); idle(); #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL halt_reset_exit: got %h expected %h", obs, 41'd0); end
    // A reset while a redirect is parked must throw the target away.
    @(negedge ip_clk); idle(); ip_jal = 1'b1; ip_jal_target = 32'hABC0; ip_icache_ready = 1'b0;
    @(negedge ip_clk); idle(); ip_icache_ready = 1'b0; #1;
    e = pack(2'd2, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pend_before_reset: got %h expected %h", obs, e); end
    @(negedge ip_clk); idle(); ip_rst = 1'b1; ip_icache_ready = 1'b0; #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL pend_reset_force: got %h expected %h", obs, 41'd0); end
    @(negedge ip_clk); idle(); #1;
    vectors++;
    if (obs !== 41'd0) begin miscompares++; $display("FAIL pend_discarded: got %h expected %h", obs, 41'd0); end
    $display("test_halt done");
  endtask

  task automatic test_random();
    int          m_mode = 0;
    logic [31:0] m_pend = 32'h0;
    int          m_stall_run = 0;
    bit          m_to = 1'b0;
    logic [40:0] e, mask;
    logic [31:0] tgt;
    bit          redir, src;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge ip_clk);
      ip_rst           = ($urandom_range(0, 99) < 3);
      ip_branch_taken  = ($urandom_range(0, 99) < 15);
      ip_branch_target = $urandom;
      ip_jal           = ($urandom_range(0, 99) < 15);
      ip_jal_target    = $urandom;
      ip_load_use      = ($urandom_range(0, 99) < 15);
      ip_muldiv_busy   = ($urandom_range(0, 99) < 20);
      ip_icache_ready  = ($urandom_range(0, 99) < 70);
      ip_done_execute  = ($urandom_range(0, 99) < 2);
      #1;
      redir = ip_branch_taken | ip_jal;
      src   = ip_load_use | ip_muldiv_busy | ~ip_icache_ready;
      tgt   = ip_branch_taken ? ip_branch_target : ip_jal_target;
      mask  = FULL;
      if (ip_rst) e = 41'd0;
      else if (m_mode == 3) e = pack(2'd3, m_to, 1, 0, 0, 0, 0, 1, 32'h0);
      else if (ip_done_execute) begin
        e = pack(m_mode[1:0], m_to, 0, 0, 0, 0, 0, 0, 32'h0);
        mask = NO_STALL;
      end else if (m_mode == 2)
        e = ip_icache_ready ? pack(2'd2, m_to, 0, 0, 0, 0, 1, 0, m_pend)
                            : pack(2'd2, m_to, 0, 0, 0, 0, 0, 1, 32'h0);
      else if (redir)
        e = ip_icache_ready ? pack(m_mode[1:0], m_to, 0, 0, ip_branch_taken, 1, 1, 0, tgt)
                            : pack(m_mode[1:0], m_to, 0, 0, ip_branch_taken, 1, 0, 1, 32'h0);
      else e = pack(m_mode[1:0], m_to, 0, src & ip_load_use, 0, 0, 0, src, 32'h0);
      vectors++;
      if ((obs & mask) !== (e & mask)) begin
        miscompares++;
        $display("FAIL random%0d: got %h expected %h", n, obs & mask, e & mask);
      end
      // Advance the model across the coming edge.
      if (ip_rst) begin
        m_mode = 0; m_pend = 32'h0; m_stall_run = 0; m_to = 1'b0;
      end else begin
        m_stall_run = (m_mode == 1) ? m_stall_run + 1 : 0;
        if (m_stall_run >= TO) m_to = 1'b1;
        if (m_mode == 3) m_mode = 3;
        else if (ip_done_execute) m_mode = 3;
        else if (m_mode == 2) m_mode = ip_icache_ready ? 0 : 2;
        else if (redir) begin
          if (!ip_icache_ready) m_pend = tgt;
          m_mode = ip_icache_ready ? 0 : 2;
        end else m_mode = src ? 1 : 0;
      end
    end
    $display("test_random done");
  endtask

  initial begin
    idle();
    ip_rst = 1'b1;
    test_reset();
    test_branch_priority();
    test_pend();
    test_load_use();
    test_watchdog();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
